// File: rtl/cv32e40p_obi_pkg.sv
// Shared OBI field widths and the response-queue entry type used by the
// memory responder and its response FIFO.
package cv32e40p_obi_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;
  localparam int unsigned OBI_AGE_W  = 4;

  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
    logic [OBI_AGE_W-1:0]  age;
  } obi_resp_t;

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO for the OBI memory responder. Each entry carries an
// age counter so the head is only released once it has waited LATENCY cycles.
module cv32e40p_obi_resp_fifo
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_push,
  input  logic [OBI_DATA_W-1:0] i_rdata,
  input  logic                  i_err,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic                  o_ready,
  output logic [OBI_DATA_W-1:0] o_rdata,
  output logic                  o_err,
  output logic [CNT_W-1:0]      o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OBI_AGE_W-1:0] AGE_SAT = OBI_AGE_W'(LATENCY);

  obi_resp_t        r_entry [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  obi_resp_t        w_head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ages advance on every slot; a stale slot's age is irrelevant because a
  // push always restarts it at 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && (r_wr_ptr == PTR_W'(i))) begin
          r_entry[i] <= '{rdata: i_rdata, err: i_err, age: OBI_AGE_W'(1)};
        end else if (r_entry[i].age < AGE_SAT) begin
          r_entry[i].age <= r_entry[i].age + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_head  = r_entry[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_ready = o_valid && (w_head.age >= AGE_SAT);
  assign o_rdata = w_head.rdata;
  assign o_err   = w_head.err;
  assign o_count = r_count;

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory-side responder: byte-enabled word memory with programmable grant
// and response stalls, bounded outstanding transactions and in-order responses.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned           MEM_WORDS       = 256,
  parameter logic [OBI_ADDR_W-1:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter int unsigned           RVALID_LATENCY  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [OBI_ADDR_W-1:0] addr_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o,
  output logic                  err_o,
  input  logic                  gnt_stall_i,
  input  logic                  rvalid_stall_i
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OBI_ADDR_W:0] MEM_BYTES = (OBI_ADDR_W + 1)'(MEM_WORDS) << 2;

  logic [OBI_DATA_W-1:0] r_mem [MEM_WORDS];

  logic [OBI_ADDR_W-1:0] w_offset;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_accept;
  logic [OBI_DATA_W-1:0] w_push_rdata;
  logic                  w_head_valid;
  logic                  w_head_ready;
  logic [OBI_DATA_W-1:0] w_head_rdata;
  logic                  w_head_err;
  logic [CNT_W-1:0]      w_count;

  // The lower-bound check guards against the subtraction wrapping around.
  assign w_offset   = addr_i - BASE_ADDR;
  assign w_in_range = (addr_i >= BASE_ADDR) && ({1'b0, w_offset} < MEM_BYTES);
  assign w_idx      = w_offset[IDX_W+1:2];

  // Outstanding count is taken at cycle start: a pop this cycle frees no slot.
  assign gnt_o    = req_i && !gnt_stall_i && (w_count < CNT_W'(MAX_OUTSTANDING));
  assign w_accept = req_i && gnt_o;

  always_ff @(posedge clk_i) begin
    if (w_accept && we_i && w_in_range) begin
      for (int k = 0; k < OBI_BE_W; k++) begin
        if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign w_push_rdata = (!we_i && w_in_range) ? r_mem[w_idx] : '0;

  cv32e40p_obi_resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .LATENCY (RVALID_LATENCY)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_accept),
    .i_rdata (w_push_rdata),
    .i_err   (!w_in_range),
    .i_pop   (rvalid_o),
    .o_valid (w_head_valid),
    .o_ready (w_head_ready),
    .o_rdata (w_head_rdata),
    .o_err   (w_head_err),
    .o_count (w_count)
  );

  assign rvalid_o = w_head_ready && !rvalid_stall_i;
  assign rdata_o  = rvalid_o ? w_head_rdata : '0;
  assign err_o    = rvalid_o && w_head_err;

`ifdef CV32E40P_ASSERT_ON
  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_count <= CNT_W'(MAX_OUTSTANDING));

  a_no_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> w_head_valid);

  a_addr_phase_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i)
                           && $stable(be_i) && $stable(wdata_i)));
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Scoreboard bench for the OBI memory responder: the driver pushes expected
// responses from a reference memory model, a negedge monitor checks grants,
// response timing and response contents.
module tb_cv32e40p_obi_mem_responder;

  localparam int unsigned MW   = 16;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int unsigned MAXO = 2;
  localparam int unsigned LAT  = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        gnt_stall_i;
  logic        rvalid_stall_i;

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS       (MW),
    .BASE_ADDR       (BASE),
    .MAX_OUTSTANDING (MAXO),
    .RVALID_LATENCY  (LAT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .gnt_stall_i    (gnt_stall_i),
    .rvalid_stall_i (rvalid_stall_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [MW];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          rmode = 0;
  bit          gmode_rand = 1'b0;

  always @(posedge clk_i) cyc++;

  // rmode: 0 = never stall responses, 1 = always stall, 2 = random stalls
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      rvalid_stall_i = (rmode == 2) ? ($urandom_range(0, 2) == 0) : (rmode == 1);
    end
  end

  function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                        input logic [3:0] be, input logic [31:0] wd,
                                        input int acc);
    exp_t e;
    int unsigned idx;
    e.acc_cyc = acc;
    e.rdata   = '0;
    e.err     = 1'b1;
    if (addr >= BASE && (addr - BASE) < 4 * MW) begin
      idx   = (addr - BASE) / 4;
      e.err = 1'b0;
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
      end else begin
        e.rdata = ref_mem[idx];
      end
    end
    return e;
  endfunction

  always @(negedge clk_i) begin
    exp_t hd;
    logic exp_gnt;
    logic exp_rv;
    if (!rst_ni) begin
      n_cmp++;
      if (rvalid_o !== 1'b0 || gnt_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
        n_mis++;
        $display("FAIL in_reset: rvalid=%b gnt=%b rdata=%h err=%b, required all zero",
                 rvalid_o, gnt_o, rdata_o, err_o);
      end
    end else begin
      exp_gnt = req_i && !gnt_stall_i && (sb.size() < MAXO);
      n_cmp++;
      if (gnt_o !== exp_gnt) begin
        n_mis++;
        $display("FAIL gnt cyc=%0d: got %b, required %b (outstanding=%0d)", cyc, gnt_o, exp_gnt, sb.size());
      end
      exp_rv = (sb.size() != 0) && (cyc >= sb[0].acc_cyc + LAT) && !rvalid_stall_i;
      n_cmp++;
      if (rvalid_o !== exp_rv) begin
        n_mis++;
        $display("FAIL rvalid cyc=%0d: got %b, required %b", cyc, rvalid_o, exp_rv);
      end
      if (rvalid_o === 1'b1 && sb.size() != 0) begin
        hd = sb.pop_front();
        n_cmp++;
        if (rdata_o !== hd.rdata || err_o !== hd.err) begin
          n_mis++;
          $display("FAIL resp cyc=%0d: got rdata=%h err=%b, required rdata=%h err=%b",
                   cyc, rdata_o, err_o, hd.rdata, hd.err);
        end
      end else if (rvalid_o !== 1'b1) begin
        n_cmp++;
        if (rdata_o !== 32'h0 || err_o !== 1'b0) begin
          n_mis++;
          $display("FAIL idle_resp cyc=%0d: got rdata=%h err=%b, required 0/0", cyc, rdata_o, err_o);
        end
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int stall_n, output int waits);
    exp_t e;
    bit   granted;
    granted = 1'b0;
    waits   = 0;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    be_i    = be;
    wdata_i = wd;
    for (int c = 0; c < 200 && !granted; c++) begin
      gnt_stall_i = gmode_rand ? ($urandom_range(0, 3) == 0) : (c < stall_n);
      @(negedge clk_i);
      if (gnt_o === 1'b1) begin
        granted = 1'b1;
        e = model_access(we, addr, be, wd, cyc);
      end else begin
        waits++;
      end
      @(posedge clk_i);
      if (granted) sb.push_back(e);
      #1;
    end
    req_i       = 1'b0;
    gnt_stall_i = 1'b0;
    if (!granted) begin
      n_mis++;
      $display("FAIL grant_timeout addr=%h: got no gnt in 200 cycles, required a grant", addr);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk_i);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d responses still pending, required 0", sb.size());
    end
  endtask

  task automatic rd(input logic [31:0] addr);
    int w;
    txn(1'b0, addr, 4'hF, 32'h0, 0, w);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int w;
    txn(1'b1, addr, be, wd, 0, w);
  endtask

  initial begin
    int w;
    int r;
    logic [31:0] a;
    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    gnt_stall_i = 1'b0; rvalid_stall_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_state: gnt=%b rvalid=%b rdata=%h err=%b, required all zero",
               gnt_o, rvalid_o, rdata_o, err_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < MW; i++) wr(BASE + 4 * i, 4'hF, $urandom);
    drain();

    wr(BASE, 4'hF, 32'hDEAD_BEEF);
    rd(BASE);
    drain();

    wr(BASE + 8, 4'hF, 32'h1122_3344);
    wr(BASE + 8, 4'b0101, 32'hAABB_CCDD);
    rd(BASE + 8);
    drain();
    n_cmp++;
    if (ref_mem[2] !== 32'h11BB_33DD) begin
      n_mis++;
      $display("FAIL partial_write_model: got %h, required %h", ref_mem[2], 32'h11BB_33DD);
    end

    // Responses held back: the third read must wait for the first rvalid
    rmode = 1;
    fork
      begin repeat (10) @(posedge clk_i); rmode = 0; end
    join_none
    rd(BASE);
    rd(BASE + 4);
    txn(1'b0, BASE + 8, 4'hF, 32'h0, 0, w);
    n_cmp++;
    if (w < 5) begin
      n_mis++;
      $display("FAIL third_read_wait: got %0d wait cycles, required at least 5", w);
    end
    drain();

    rd(BASE + 4 * MW);
    wr(BASE + 4 * MW, 4'hF, 32'hFFFF_FFFF);
    rd(BASE + 4 * MW - 1);
    rd(BASE - 4);
    for (int i = 0; i < MW; i++) rd(BASE + 4 * i);
    drain();

    txn(1'b0, BASE + 12, 4'hF, 32'h0, 5, w);
    n_cmp++;
    if (w != 5) begin
      n_mis++;
      $display("FAIL gnt_stall_wait: got %0d cycles without gnt, required 5", w);
    end
    drain();

    // Reset with two responses aged and ready to go
    wr(BASE + 20, 4'hF, 32'hCAFE_F00D);
    drain();
    rmode = 1;
    rd(BASE);
    rd(BASE + 4);
    repeat (5) @(posedge clk_i);
    #3 rmode = 0;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_mid_op: got rvalid=%b rdata=%h, required 0/0", rvalid_o, rdata_o);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rd(BASE + 20);
    rd(BASE + 8);
    drain();

    gmode_rand = 1'b1;
    rmode = 2;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16)       a = BASE + 4 * r + $urandom_range(0, 3);
      else if (r < 18) a = BASE + 4 * MW + 4 * $urandom_range(0, 3);
      else if (r == 18) a = BASE - 4;
      else              a = BASE + 4 * MW - 1;
      txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 0, w);
    end
    gmode_rand = 1'b0;
    rmode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
